// File: rtl/esteira_pkg.sv
// Shared encodings for the bottling-line conveyor controller: state codes,
// station phase and the phase-timer width.
package esteira_pkg;

  typedef enum logic [2:0] {
    PARADO                = 3'b000,
    AGUARDANDO_ENCHIMENTO = 3'b001,
    AGUARDANDO_VEDACAO    = 3'b010,
    FALTA_ROLHA           = 3'b011,
    AGUARDANDO_CQ         = 3'b100,
    AGUARDANDO_LACRE      = 3'b101
  } estado_t;

  typedef enum logic {
    TRANSP = 1'b0,
    PARK   = 1'b1
  } fase_t;

  localparam int TIMER_W = 16;
  typedef logic [TIMER_W-1:0] timer_t;

endpackage

// File: rtl/divisor_tick.sv
// Free-running prescaler: one-cycle tick every TICK_CLKS clocks, counting from reset.
module divisor_tick #(
  parameter int TICK_CLKS = 50_000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick
);

  localparam int CW = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(TICK_CLKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == ULTIMO) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == ULTIMO);

endmodule

// File: rtl/controle_esteira.sv
// Conveyor sequencer: fill -> cork -> quality control -> seal, one bottle at a time,
// with cork stock tracking and a sealed-bottle counter. All outputs are registered.
module controle_esteira
  import esteira_pkg::*;
#(
  parameter int TICK_CLKS  = 50_000,
  parameter int T_TRANSP   = 1000,
  parameter int T_VEDACAO  = 500,
  parameter int T_LACRE    = 500,
  parameter int ROLHAS_MAX = 15
) (
  input  logic       MAX10_CLK1_50,
  input  logic       reset,
  input  logic       liga,
  input  logic       sensor_nivel,
  input  logic       cq_valido,
  input  logic       cq_aprovado,
  input  logic       repor_rolhas,
  output logic [2:0] estado_atual,
  output logic       motor,
  output logic       Motor_Parado_Pos_Enchimento,
  output logic       Motor_Parado_Pos_CQ,
  output logic       Motor_Parado_Pos_Lacre,
  output logic       val_enchimento,
  output logic [3:0] rolhas,
  output logic [7:0] garrafas_lacradas,
  output logic       descarte
);

  estado_t    est_q, est_d;
  fase_t      fase_q, fase_d;
  timer_t     tmr_q, tmr_d;
  logic [3:0] rol_q, rol_d;
  logic [7:0] gar_q, gar_d;
  logic       tick;
  logic       fim_transp, fim_ved, fim_lacre;
  logic       desc_d, motor_d, p_ench_d, p_cq_d, p_lacre_d;
  logic       motor_q, p_ench_q, p_cq_q, p_lacre_q, val_q, desc_q;

  divisor_tick #(.TICK_CLKS(TICK_CLKS)) u_tick (
    .clk_i (MAX10_CLK1_50),
    .rst_i (reset),
    .tick  (tick)
  );

  // A phase ends on the tick that would bring the timer to its target.
  assign fim_transp = tick && (tmr_q == timer_t'(T_TRANSP - 1));
  assign fim_ved    = tick && (tmr_q == timer_t'(T_VEDACAO - 1));
  assign fim_lacre  = tick && (tmr_q == timer_t'(T_LACRE - 1));

  always_comb begin
    est_d  = est_q;
    fase_d = fase_q;
    rol_d  = rol_q;
    gar_d  = gar_q;
    desc_d = 1'b0;
    case (est_q)
      PARADO:
        if (liga) begin
          est_d  = AGUARDANDO_ENCHIMENTO;
          fase_d = TRANSP;
        end
      AGUARDANDO_ENCHIMENTO:
        if (fase_q == TRANSP) begin
          if (fim_transp) fase_d = PARK;
        end else if (sensor_nivel) begin
          est_d  = (rol_q != 4'd0) ? AGUARDANDO_VEDACAO : FALTA_ROLHA;
          fase_d = TRANSP;
        end
      AGUARDANDO_VEDACAO:
        if (fim_ved) begin
          rol_d  = rol_q - 4'd1;
          est_d  = AGUARDANDO_CQ;
          fase_d = TRANSP;
        end
      FALTA_ROLHA:
        if (repor_rolhas) est_d = AGUARDANDO_VEDACAO;
      AGUARDANDO_CQ:
        if (fase_q == TRANSP) begin
          if (fim_transp) fase_d = PARK;
        end else if (cq_valido) begin
          fase_d = TRANSP;
          if (cq_aprovado) begin
            est_d = AGUARDANDO_LACRE;
          end else begin
            desc_d = 1'b1;
            if (liga) est_d = AGUARDANDO_ENCHIMENTO;
            else      est_d = PARADO;
          end
        end
      AGUARDANDO_LACRE:
        if (fase_q == TRANSP) begin
          if (fim_transp) fase_d = PARK;
        end else if (fim_lacre) begin
          gar_d  = gar_q + 8'd1;
          fase_d = TRANSP;
          if (liga) est_d = AGUARDANDO_ENCHIMENTO;
          else      est_d = PARADO;
        end
      default: begin
        est_d  = PARADO;
        fase_d = TRANSP;
      end
    endcase

    // A refill overrides any decrement happening on the same edge.
    if (repor_rolhas) rol_d = 4'(ROLHAS_MAX);

    if ((est_d != est_q) || (fase_d != fase_q)) tmr_d = '0;
    else                                        tmr_d = tmr_q + timer_t'(tick);

    // Outputs are decoded from the next state so they move with the state register.
    motor_d   = (fase_d == TRANSP) && ((est_d == AGUARDANDO_ENCHIMENTO) ||
                                       (est_d == AGUARDANDO_CQ) ||
                                       (est_d == AGUARDANDO_LACRE));
    p_ench_d  = (fase_d == PARK) && (est_d == AGUARDANDO_ENCHIMENTO);
    p_cq_d    = (fase_d == PARK) && (est_d == AGUARDANDO_CQ);
    p_lacre_d = (fase_d == PARK) && (est_d == AGUARDANDO_LACRE);
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      est_q     <= PARADO;
      fase_q    <= TRANSP;
      tmr_q     <= '0;
      rol_q     <= 4'(ROLHAS_MAX);
      gar_q     <= '0;
      motor_q   <= 1'b0;
      p_ench_q  <= 1'b0;
      p_cq_q    <= 1'b0;
      p_lacre_q <= 1'b0;
      val_q     <= 1'b0;
      desc_q    <= 1'b0;
    end else begin
      est_q     <= est_d;
      fase_q    <= fase_d;
      tmr_q     <= tmr_d;
      rol_q     <= rol_d;
      gar_q     <= gar_d;
      motor_q   <= motor_d;
      p_ench_q  <= p_ench_d;
      p_cq_q    <= p_cq_d;
      p_lacre_q <= p_lacre_d;
      val_q     <= p_ench_d;
      desc_q    <= desc_d;
    end
  end

  assign estado_atual                = est_q;
  assign motor                       = motor_q;
  assign Motor_Parado_Pos_Enchimento = p_ench_q;
  assign Motor_Parado_Pos_CQ         = p_cq_q;
  assign Motor_Parado_Pos_Lacre      = p_lacre_q;
  assign val_enchimento              = val_q;
  assign rolhas                      = rol_q;
  assign garrafas_lacradas           = gar_q;
  assign descarte                    = desc_q;

endmodule

// File: doc/controle_esteira.md
# controle_esteira

Conveyor controller for the wine-bottling line: sequences one bottle at a time through filling, corking, quality control (CQ) and sealing, driving the belt motor and filling valve. It is the producing end of the status interface consumed by the VGA display top: `estado_atual`, `motor`, the three `Motor_Parado_Pos_*` flags and `val_enchimento` come from this block. It also tracks cork stock and counts sealed bottles.

## Interface
- `TICK_CLKS`, 50_000: clock cycles per timer tick (1 ms at 50 MHz).
- `T_TRANSP`, 1000: ticks of belt motion between stations.
- `T_VEDACAO`, 500: ticks to cork a bottle.
- `T_LACRE`, 500: ticks to seal a bottle.
- `ROLHAS_MAX`, 15: cork stock after reset or refill; must be 1..15.

Ports:
- `MAX10_CLK1_50`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `liga`  in  1  run enable, level.
- `sensor_nivel`  in  1  bottle full.
- `cq_valido`  in  1  CQ verdict strobe.
- `cq_aprovado`  in  1  CQ verdict, qualified by `cq_valido`.
- `repor_rolhas`  in  1  cork refill pulse.
- `estado_atual`  out  3  state code.
- `motor`  out  1  belt running.
- `Motor_Parado_Pos_Enchimento`  out  1  bottle parked at filler.
- `Motor_Parado_Pos_CQ`  out  1  bottle parked at CQ.
- `Motor_Parado_Pos_Lacre`  out  1  bottle parked at sealer.
- `val_enchimento`  out  1  filling valve open.
- `rolhas`  out  4  corks remaining.
- `garrafas_lacradas`  out  8  sealed-bottle count; wraps 255→0.
- `descarte`  out  1  one-cycle pulse when a bottle is rejected.

## Operation
- State codes:
  - PARADO 000
  - AGUARDANDO_ENCHIMENTO 001
  - AGUARDANDO_VEDACAO 010
  - FALTA_ROLHA 011
  - AGUARDANDO_CQ 100
  - AGUARDANDO_LACRE 101
  - Codes 110 and 111 are illegal and go to PARADO.
- ENCHIMENTO, CQ and LACRE each have two phases: TRANSP, with `motor`=1 for `T_TRANSP` ticks, then PARK, with `motor`=0 and the station's `Motor_Parado_Pos_*`=1.
- PARADO: `motor`=0. When `liga`=1, go to ENCHIMENTO/TRANSP.
- ENCHIMENTO/PARK: `val_enchimento`=1. On `sensor_nivel`=1, close the valve, then:
  - `rolhas`>0 → VEDACAO.
  - `rolhas`=0 → FALTA_ROLHA.
- VEDACAO: `motor`=0 for `T_VEDACAO` ticks. At expiry, `rolhas`−1 and go to CQ/TRANSP.
- FALTA_ROLHA: `motor`=0. On `repor_rolhas`, go to VEDACAO.
- CQ/PARK: wait for `cq_valido`.
  - `cq_aprovado`=1 → LACRE/TRANSP.
  - `cq_aprovado`=0 → `descarte` pulse, then restart (see restart rule).
- LACRE/PARK: wait `T_LACRE` ticks, then `garrafas_lacradas`+1 and restart.
- Restart rule: go to ENCHIMENTO/TRANSP if `liga`=1, else PARADO. `liga` is sampled only in PARADO and at restart, so the bottle in flight always completes.
- Input qualification:
  - `sensor_nivel` is ignored outside ENCHIMENTO/PARK.
  - `cq_valido` is ignored outside CQ/PARK.
- `repor_rolhas` loads `rolhas`=`ROLHAS_MAX` in any state. If it coincides with the VEDACAO decrement, the reload wins.

## Timing
- Reset values:
  - state PARADO, phase TRANSP.
  - All 1-bit outputs 0.
  - `rolhas`=`ROLHAS_MAX`.
  - `garrafas_lacradas`=0.
  - Tick prescaler and phase timer 0.
- All outputs are registered and reflect a transition on the same edge the state register updates.
- Input-driven transitions (`sensor_nivel`, `cq_valido`, `repor_rolhas`, `liga`): outputs update on the first rising edge at which the input is sampled high (1-cycle latency).
- Tick: one-cycle strobe every `TICK_CLKS` clocks, free-running from reset.
- Phase timer (16 bits):
  - Cleared on every state or phase change.
  - Increments on tick.
  - The phase ends on the clock edge of the tick that brings it to the target N.
  - The first tick may be partial, so phase duration is (N−1)·`TICK_CLKS`+1 to N·`TICK_CLKS` cycles.
- `descarte` is high for exactly the cycle in which the state leaves CQ on a rejection.
- Reset asserted mid-operation aborts immediately to reset values; the partial bottle is not counted.

## Structure
- Package `esteira_pkg`: the six state codes, phase encoding (TRANSP=0, PARK=1), and the timer width.
- Sub-module `divisor_tick` (parameter `TICK_CLKS`; ports clock, reset, `tick` out): the prescaler.
- The remainder is a single always block for state, phase and timer, plus registered output decode.

## Test plan
Bench parameters: `TICK_CLKS`=4, `T_TRANSP`=3, `T_VEDACAO`=2, `T_LACRE`=2, `ROLHAS_MAX`=2.

- **Happy path.** Reset, `liga`=1, then `sensor_nivel` pulse in PARK, then `cq_valido`+`cq_aprovado`. Required:
  - States 001→010→100→101→001.
  - `motor` high 9–12 cycles per TRANSP.
  - `garrafas_lacradas`=1, `rolhas`=1.
- **Cork exhaustion.** Run two bottles, then fill a third. Required:
  - State 011, `motor`=0.
  - `repor_rolhas` → 010 next edge, `rolhas`=2, then 1 after corking.
- **CQ reject.** `cq_valido`=1, `cq_aprovado`=0. Required:
  - `descarte` high exactly 1 cycle.
  - Next state 001, count unchanged.
- **Stop and out-of-phase inputs.** Drop `liga` during CQ; assert `sensor_nivel` and `cq_valido` during TRANSP. Required:
  - The current bottle still seals, then state 000.
  - The stray inputs cause no transition.
- **Async reset.** Reset mid-ENCHIMENTO/PARK with `val_enchimento`=1. Required:
  - Outputs zero without waiting for a clock edge.
  - State 000, `rolhas`=2.
- **Refill collision and wrap.** `repor_rolhas` on the VEDACAO expiry edge → `rolhas`=2. Preload the count at 255 → next seal gives 0.
